// File: rtl/rotate_scheduler_if.sv
// Request/result bundle for the shared rotator.
// Requester side is master, scheduler is slave.
interface rotate_scheduler_if #(
  parameter int N = 3,
  parameter int R = 4
);
  localparam int W  = 2**N;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*W-1:0] req_data;
  logic [R*N-1:0] req_amt;
  logic [R-1:0]   req_dir;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           busy;

  modport master (
    output req_valid, req_data, req_amt,
    output req_dir, out_ready,
    input  req_ready, out_valid, out_data,
    input  out_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt,
    input  req_dir, out_ready,
    output req_ready, out_valid, out_data,
    output out_id, busy
  );
endinterface

// File: rtl/rotate_scheduler.sv
// Round-robin scheduler sharing one rotator.
// One transaction in flight: IDLE -> EXEC -> HOLD.
module rotate_scheduler #(
  parameter int N = 3,
  parameter int R = 4
) (
  input logic               clk,
  input logic               reset,
  rotate_scheduler_if.slave bus
);
  localparam int W  = 2**N;
  localparam int IW = $clog2(R);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt;
  logic            gnt_vld;
  logic            accept;
  logic [W-1:0]    op_data;
  logic [N-1:0]    op_amt;
  logic            op_dir;
  logic [IW-1:0]   op_id;
  logic [N-1:0]    k;
  logic [2*W-1:0]  dbl;
  logic [W-1:0]    rot;

  // Round-robin search starting after last grant
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (!gnt_vld &&
          bus.req_valid[(int'(last_grant) + 1 + i) % R]) begin
        gnt     = IW'((int'(last_grant) + 1 + i) % R);
        gnt_vld = 1'b1;
      end
    end
  end

  // Left rotate is a right rotate by the negated amount
  assign k   = op_dir ? (~op_amt + N'(1)) : op_amt;
  assign dbl = {op_data, op_data} >> k;
  assign rot = dbl[W-1:0];

  assign bus.busy = (state != IDLE);

  // Next state and grant strobe
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld && !reset) begin
          bus.req_ready[gnt] = 1'b1;
          accept             = 1'b1;
          state_nx           = EXEC;
        end
      end
      EXEC: state_nx = HOLD;
      HOLD: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture, result register, grant pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= IW'(R - 1);
      op_data       <= '0;
      op_amt        <= '0;
      op_dir        <= 1'b0;
      op_id         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else begin
      if (accept) begin
        op_data    <= bus.req_data[int'(gnt)*W +: W];
        op_amt     <= bus.req_amt[int'(gnt)*N +: N];
        op_dir     <= bus.req_dir[gnt];
        op_id      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        bus.out_data  <= rot;
        bus.out_id    <= op_id;
        bus.out_valid <= 1'b1;
      end else if (state == HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
